video_sync_capture: RTL and testbench

//  Receive end of the game video output: takes the active-low H/V syncs and 3-bit RGB

---
 rtl/video_sync_capture.sv | 178 +++++++++++++++++
 tb/tb_video_sync_capture.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/video_sync_capture.sv
// Sync receiver: rebuilds pixel/line counters from active-low H/V syncs, measures timing,
// acquires lock over consistent frames and writes the active picture to a framebuffer port.
module video_sync_capture #(
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int H_START     = 128,
    parameter int V_START     = 16,
    parameter int ACT_W       = 256,
    parameter int ACT_H       = 224,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    input  logic           hsync_n,
    input  logic           vsync_n,
    input  logic [2:0]     rgb,
    input  logic           capture_en,
    output logic           wr_en,
    output logic [15:0]    wr_addr,
    output logic [2:0]     wr_data,
    output logic [X_W-1:0] line_len,
    output logic [Y_W-1:0] frame_lines,
    output logic           locked,
    output logic           frame_done,
    output logic           sync_err
);
    localparam int G_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [X_W-1:0] H_MAX = '1;
    localparam logic [Y_W-1:0] V_MAX = '1;

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t           state_reg, state_next;
    logic [G_W-1:0]   good_cnt_reg, good_cnt_next;
    logic             lines_valid_reg, lines_valid_next;
    logic             sync_err_reg, sync_err_next;
    logic             hs_prev_reg, vs_prev_reg, vs_pending_reg;
    logic [X_W-1:0]   h_cnt_reg, line_len_reg, ref_len_reg;
    logic [Y_W-1:0]   v_cnt_reg, frame_lines_reg;
    logic             ref_valid_reg, frame_bad_reg;
    logic             frame_done_reg, wr_en_reg;
    logic [15:0]      wr_addr_reg;
    logic [2:0]       wr_data_reg;

    logic             hs_edge, vs_edge, boundary, sat, len_bad, frame_ok, cap;
    logic [X_W-1:0]   h_cur, meas_len, h_rel;
    logic [Y_W-1:0]   v_cur, meas_lines, v_rel;

    assign hs_edge    = pix_en & hs_prev_reg & ~hsync_n;
    assign vs_edge    = pix_en & vs_prev_reg & ~vsync_n;
    // A frame boundary is always aligned to a line start, even if vsync fell mid-line.
    assign boundary   = hs_edge & (vs_pending_reg | vs_edge);
    assign meas_len   = h_cnt_reg + 1'b1;
    assign meas_lines = v_cnt_reg + 1'b1;

    // Counter values that belong to the current sample (the hs_edge sample is pixel 0).
    always_comb begin
        h_cur = h_cnt_reg;
        v_cur = v_cnt_reg;
        if (hs_edge)
            h_cur = '0;
        else if (h_cnt_reg != H_MAX)
            h_cur = h_cnt_reg + 1'b1;
        if (boundary)
            v_cur = '0;
        else if (hs_edge && v_cnt_reg != V_MAX)
            v_cur = v_cnt_reg + 1'b1;
    end

    // Saturation is flagged on the sample that drives a counter onto its ceiling (or holds it there).
    assign sat      = pix_en & ((~hs_edge & (h_cnt_reg >= H_MAX - 1'b1)) |
                                (hs_edge & ~boundary & (v_cnt_reg >= V_MAX - 1'b1)));
    assign len_bad  = hs_edge & ref_valid_reg & (meas_len != ref_len_reg);
    assign frame_ok = ~(frame_bad_reg | len_bad | sat) &
                      (~lines_valid_reg | (meas_lines == frame_lines_reg));

    always_comb begin
        state_next       = state_reg;
        good_cnt_next    = good_cnt_reg;
        lines_valid_next = lines_valid_reg;
        sync_err_next    = 1'b0;
        case (state_reg)
            SEARCH: if (boundary) begin
                state_next       = TRACK;
                good_cnt_next    = '0;
                lines_valid_next = 1'b0;
            end
            TRACK: if (boundary) begin
                lines_valid_next = 1'b1;
                if (!frame_ok)
                    good_cnt_next = '0;
                else begin
                    good_cnt_next = good_cnt_reg + 1'b1;
                    if (int'(good_cnt_reg) + 1 >= LOCK_FRAMES)
                        state_next = LOCKED;
                end
            end
            LOCKED: if (sat || (boundary && !frame_ok)) begin
                state_next    = SEARCH;
                good_cnt_next = '0;
                sync_err_next = 1'b1;
            end
            default: state_next = SEARCH;
        endcase
    end

    assign h_rel = h_cur - X_W'(H_START);
    assign v_rel = v_cur - Y_W'(V_START);
    assign cap   = pix_en & capture_en & (state_reg == LOCKED) & (state_next == LOCKED) &
                   (h_cur >= X_W'(H_START)) & (h_cur < X_W'(H_START + ACT_W)) &
                   (v_cur >= Y_W'(V_START)) & (v_cur < Y_W'(V_START + ACT_H));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= SEARCH;
            good_cnt_reg    <= '0;
            lines_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
            hs_prev_reg     <= 1'b0;
            vs_prev_reg     <= 1'b0;
            vs_pending_reg  <= 1'b0;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            line_len_reg    <= '0;
            frame_lines_reg <= '0;
            ref_len_reg     <= '0;
            ref_valid_reg   <= 1'b0;
            frame_bad_reg   <= 1'b0;
            frame_done_reg  <= 1'b0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            good_cnt_reg    <= good_cnt_next;
            lines_valid_reg <= lines_valid_next;
            sync_err_reg    <= sync_err_next;
            frame_done_reg  <= boundary;
            wr_en_reg       <= cap;
            if (cap) begin
                wr_addr_reg <= {v_rel[7:0], h_rel[7:0]};
                wr_data_reg <= rgb;
            end
            if (pix_en) begin
                hs_prev_reg <= hsync_n;
                vs_prev_reg <= vsync_n;
                h_cnt_reg   <= h_cur;
                v_cnt_reg   <= v_cur;
                if (hs_edge)
                    line_len_reg <= meas_len;
                if (boundary) begin
                    frame_lines_reg <= meas_lines;
                    vs_pending_reg  <= 1'b0;
                    ref_valid_reg   <= 1'b0;
                    frame_bad_reg   <= 1'b0;
                end else begin
                    if (vs_edge)
                        vs_pending_reg <= 1'b1;
                    frame_bad_reg <= frame_bad_reg | len_bad | sat;
                    if (hs_edge && !ref_valid_reg) begin
                        ref_len_reg   <= meas_len;
                        ref_valid_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign line_len    = line_len_reg;
    assign frame_lines = frame_lines_reg;
    assign locked      = (state_reg == LOCKED);
    assign frame_done  = frame_done_reg;
    assign sync_err    = sync_err_reg;
endmodule

// File: tb/tb_video_sync_capture.sv
// Bench for video_sync_capture: a reduced raster (48 px x 12 lines) driven frame by frame
// from a table, with expected framebuffer writes queued and matched as they appear.
module tb_video_sync_capture;
    localparam int LEN    = 48;
    localparam int LINES  = 12;
    localparam int HS_W   = 4;
    localparam int VS_L   = 2;
    localparam int TAIL_P = 30;
    localparam int HST    = 8;
    localparam int VST    = 2;
    localparam int AW     = 16;
    localparam int AH     = 4;

    logic        clk = 1'b0;
    logic        rst, pix_en, hsync_n, vsync_n, capture_en;
    logic [2:0]  rgb;
    logic        wr_en, locked, frame_done, sync_err;
    logic [15:0] wr_addr;
    logic [2:0]  wr_data;
    logic [9:0]  line_len;
    logic [8:0]  frame_lines;

    video_sync_capture #(.X_W(10), .Y_W(9), .H_START(HST), .V_START(VST),
                         .ACT_W(AW), .ACT_H(AH), .LOCK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .rgb(rgb), .capture_en(capture_en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .line_len(line_len), .frame_lines(frame_lines),
        .locked(locked), .frame_done(frame_done), .sync_err(sync_err));

    always #5 clk = ~clk;

    typedef struct {
        bit tail;       // vsync falls in the last line (mid-line) instead of with hsync
        int short_line; // line shortened by one pixel, -1 for none
        bit cap_off;    // drop capture_en after line 3 pixel 20
        bit exp_cap;    // writes expected in this frame
        bit lk_start;   // locked after the opening boundary
        bit err_start;  // sync_err after the opening boundary
        bit chk_meas;   // line_len/frame_lines meaningful at the opening boundary
    } frame_vec_t;

    frame_vec_t   tbl [9];
    logic [18:0]  exp_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;
    bit           prev_tail = 0;
    logic         last_done, last_err, last_lk;
    logic [15:0]  last_addr;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_wr();
        logic [18:0] e;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", int'(wr_addr), -1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), int'(e[18:3]));
                check("wr_data", int'(wr_data), int'(e[2:0]));
                $display("[TB] write addr=%04h data=%0d", wr_addr, wr_data);
            end
            last_addr = wr_addr;
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("missing_wr", 0, int'(e[18:3]) + 1);
        end
    endtask

    // One pixel sample followed by one idle clock (pix_en low, state must hold).
    task automatic do_sample(input logic hs, input logic vs, input logic [2:0] c,
                             input bit ew, input logic [15:0] ea);
        hsync_n = hs; vsync_n = vs; rgb = c; pix_en = 1'b1;
        if (ew) exp_q.push_back({ea, c});
        @(posedge clk); #1;
        pix_en = 1'b0;
        check_wr();
        last_done = frame_done; last_err = sync_err; last_lk = locked;
        @(posedge clk); #1;
        check("wr_one_clk", int'(wr_en), 0);
    endtask

    task automatic run_frame(input frame_vec_t r, input int idx);
        int len;
        bit head_low, tail_low, ew;
        logic [2:0] c;
        capture_en = 1'b1;
        for (int l = 0; l < LINES; l++) begin
            len = (l == r.short_line) ? LEN - 1 : LEN;
            for (int p = 0; p < len; p++) begin
                head_low = prev_tail ? (l < VS_L - 1 || (l == VS_L - 1 && p < TAIL_P)) : (l < VS_L);
                tail_low = r.tail && l == LINES - 1 && p >= TAIL_P;
                ew = r.exp_cap && capture_en && l >= VST && l < VST + AH && p >= HST && p < HST + AW;
                c = 3'($urandom_range(0, 7));
                do_sample(p >= HS_W, !(head_low || tail_low), c, ew, {8'(l - VST), 8'(p - HST)});
                if (l == 0 && p == 0) begin
                    $display("[TB] frame %0d boundary: done=%0d locked=%0d sync_err=%0d len=%0d lines=%0d",
                             idx, last_done, last_lk, last_err, line_len, frame_lines);
                    check("frame_done", int'(last_done), 1);
                    check("locked", int'(last_lk), int'(r.lk_start));
                    check("sync_err", int'(last_err), int'(r.err_start));
                    if (r.chk_meas) begin
                        check("line_len", int'(line_len), LEN);
                        check("frame_lines", int'(frame_lines), LINES);
                    end
                end
                if (r.cap_off && l == 3 && p == 20) capture_en = 1'b0;
            end
        end
        prev_tail = r.tail;
        if (r.cap_off) check("last_addr_capoff", int'(last_addr), int'({8'd1, 8'd12}));
    endtask

    task automatic run_table(input int n);
        prev_tail = 0;
        for (int i = 0; i < 8; i++) do_sample(1'b1, 1'b1, 3'd0, 1'b0, 16'd0);
        for (int i = 0; i < n; i++) run_frame(tbl[i], i);
    endtask

    initial begin
        int k_err;
        //          tail short cap_off exp_cap lk  err meas
        tbl[0] = '{1, -1, 0, 0, 0, 0, 0};   // first boundary: SEARCH -> TRACK
        tbl[1] = '{1, -1, 0, 0, 0, 0, 1};   // first good frame
        tbl[2] = '{1, -1, 0, 1, 1, 0, 1};   // second good frame -> locked, full capture
        tbl[3] = '{0, -1, 1, 1, 1, 0, 1};   // capture_en dropped mid-line
        tbl[4] = '{1,  8, 0, 1, 1, 0, 1};   // coincident syncs; one short line
        tbl[5] = '{1, -1, 0, 0, 0, 1, 1};   // lock lost at boundary
        tbl[6] = '{1, -1, 0, 0, 0, 0, 1};   // SEARCH -> TRACK
        tbl[7] = '{1, -1, 0, 0, 0, 0, 1};
        tbl[8] = '{0, -1, 0, 1, 1, 0, 1};   // re-locked
        rst = 1'b1; pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1; rgb = 3'd0; capture_en = 1'b1;
        last_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", int'({wr_en, wr_addr, wr_data, locked, frame_done, sync_err}), 0);
        check("rst_line_len", int'(line_len), 0);
        check("rst_frame_lines", int'(frame_lines), 0);
        rst = 1'b0;

        run_table(9);

        // hsync stuck high while locked: h_cnt runs from 47 to its ceiling.
        k_err = -1;
        for (int k = 1; k <= 1100 && k_err < 0; k++) begin
            do_sample(1'b1, 1'b1, 3'd0, 1'b0, 16'd0);
            if (last_err) k_err = k;
        end
        $display("[TB] saturation: sync_err after %0d stuck samples", k_err);
        check("sat_sync_err_window", int'(k_err >= 970 && k_err <= 980), 1);
        check("sat_locked", int'(locked), 0);

        // Asynchronous reset in the middle of a clock period.
        check("pre_rst_line_len", int'(line_len), LEN);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midrst_outputs", int'({wr_en, wr_addr, wr_data, locked, frame_done, sync_err}), 0);
        check("midrst_line_len", int'(line_len), 0);
        check("midrst_frame_lines", int'(frame_lines), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();

        // Lock is re-acquired from scratch.
        run_table(3);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
